param_counter: RTL

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 60 ++++++
 rtl/counter_prescaler.sv | 34 +++
 rtl/param_counter.sv | 77 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared counter definitions: saturation encodings, parameter legality and
// range-limit helpers used by the counter RTL and the existing counter bench.
package counter_pkg;

    typedef enum logic {
        SAT_WRAP = 1'b0,
        SAT_HOLD = 1'b1
    } sat_mode_e;

    localparam int MIN_WIDTH    = 2;
    localparam int MAX_WIDTH    = 32;
    localparam int MIN_PRESCALE = 1;
    localparam int MAX_PRESCALE = 256;

    function automatic bit prescale_legal(input int prescale);
        return (prescale >= MIN_PRESCALE) && (prescale <= MAX_PRESCALE);
    endfunction

    function automatic bit params_legal(input int width, input longint modulo,
                                        input int sat, input int prescale);
        bit ok;
        ok = (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
        ok = ok && (modulo >= 2) && (modulo <= (longint'(1) << width));
        ok = ok && ((sat == 0) || (sat == 1));
        ok = ok && prescale_legal(prescale);
        return ok;
    endfunction

    function automatic sat_mode_e sat_mode(input int sat);
        return (sat != 0) ? SAT_HOLD : SAT_WRAP;
    endfunction

    // The range end is direction dependent: last value going up, zero going down.
    function automatic logic at_range_end(input logic [31:0] q, input logic up,
                                          input logic [31:0] last);
        return up ? (q == last) : (q == 32'd0);
    endfunction

    // A load value v is in range when v < MODULO, i.e. v <= MODULO-1.
    function automatic logic [31:0] clamp_load(input logic [31:0] v,
                                               input logic [31:0] last);
        return (v > last) ? last : v;
    endfunction

    function automatic logic [31:0] next_count(input logic [31:0] q, input logic up,
                                               input logic [31:0] last,
                                               input sat_mode_e mode);
        logic [31:0] r;
        if (at_range_end(q, up, last)) begin
            if (mode == SAT_HOLD)
                r = q;
            else
                r = up ? 32'd0 : last;
        end else begin
            r = up ? (q + 32'd1) : (q - 32'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler: counts qualified enable cycles and emits one step every PRESCALE of them.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstb,
    input  logic in,
    input  logic clr,
    output logic step
);
    import counter_pkg::*;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(PRESCALE - 1);

    if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
        $error("counter_prescaler: PRESCALE out of range 1..256");
    end

    logic [PW-1:0] phase;

    assign step = in & ~clr & (phase == PHASE_LAST);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (in) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/param_counter.sv
// Parameterised up/down modulo counter with prescaler, load, clear,
// optional saturation, terminal-count pulse and sticky overflow flag.
module param_counter #(
    parameter int     WIDTH    = 4,
    parameter longint MODULO   = 16,
    parameter int     SAT      = 0,
    parameter int     PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);
    import counter_pkg::*;

    if (!params_legal(WIDTH, MODULO, SAT, PRESCALE)) begin : g_bad_params
        $error("param_counter: illegal WIDTH/MODULO/SAT/PRESCALE combination");
    end

    // All range arithmetic runs on 32-bit views so MODULO = 2^WIDTH wraps naturally.
    localparam logic [31:0] LAST = 32'(MODULO - 1);
    localparam sat_mode_e   MODE = sat_mode(SAT);

    logic             step;
    logic             prescale_clr;
    logic             range_end;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_load;

    assign prescale_clr = clr | load;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rstb (rstb),
        .in   (in),
        .clr  (prescale_clr),
        .step (step)
    );

    always_comb begin
        range_end = at_range_end(32'(Q), up_dn, LAST);
        q_next    = WIDTH'(next_count(32'(Q), up_dn, LAST, MODE));
        q_load    = WIDTH'(clamp_load(32'(load_val), LAST));
    end

    // Priority: clr, then load, then a prescaled step, else hold.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            Q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (clr) begin
            Q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else if (load) begin
            Q   <= q_load;
            tc  <= 1'b0;
        end else if (step) begin
            Q   <= q_next;
            tc  <= range_end;
            if (range_end)
                ovf <= 1'b1;
        end else begin
            tc  <= 1'b0;
        end
    end

endmodule
